// File: rtl/count_display_pkg.sv
`default_nettype none
//==============================================================================
// Module : count_display_pkg
// Brief  : Shared converter state encoding, segment codes and decode helpers.
// Rev    : 1.0
//==============================================================================
package count_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  localparam int c_idx_w = 2;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_seg_0     = 7'h40;
  localparam logic [6:0] c_seg_1     = 7'h79;
  localparam logic [6:0] c_seg_2     = 7'h24;
  localparam logic [6:0] c_seg_3     = 7'h30;
  localparam logic [6:0] c_seg_4     = 7'h19;
  localparam logic [6:0] c_seg_5     = 7'h12;
  localparam logic [6:0] c_seg_6     = 7'h02;
  localparam logic [6:0] c_seg_7     = 7'h78;
  localparam logic [6:0] c_seg_8     = 7'h00;
  localparam logic [6:0] c_seg_9     = 7'h10;
  localparam logic [6:0] c_seg_u     = 7'h41;
  localparam logic [6:0] c_seg_d     = 7'h21;
  localparam logic [6:0] c_seg_blank = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = c_seg_0;
      4'd1:    code = c_seg_1;
      4'd2:    code = c_seg_2;
      4'd3:    code = c_seg_3;
      4'd4:    code = c_seg_4;
      4'd5:    code = c_seg_5;
      4'd6:    code = c_seg_6;
      4'd7:    code = c_seg_7;
      4'd8:    code = c_seg_8;
      4'd9:    code = c_seg_9;
      default: code = c_seg_blank;
    endcase
    return code;
  endfunction

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift
  function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
    logic [11:0] adj;
    adj = bcd;
    if (adj[3:0]  >= 4'd5) adj[3:0]  = adj[3:0]  + 4'd3;
    if (adj[7:4]  >= 4'd5) adj[7:4]  = adj[7:4]  + 4'd3;
    if (adj[11:8] >= 4'd5) adj[11:8] = adj[11:8] + 4'd3;
    return adj;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_display_if.sv
`default_nettype none
//==============================================================================
// Module : count_display_if
// Brief  : Counter input and 4-digit display output bundle.
// Rev    : 1.0
//==============================================================================
interface count_display_if;
  logic [7:0] q;
  logic       ud;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output q, ud, input an, seg, dp);
  modport slave  (input q, ud, output an, seg, dp);
endinterface
`default_nettype wire

// File: rtl/bcd8_converter.sv
`default_nettype none
//==============================================================================
// Module : bcd8_converter
// Brief  : 10-cycle IDLE/SHIFT/LOAD binary-to-BCD converter with LOAD valid pulse.
// Rev    : 1.0
//==============================================================================
module bcd8_converter
  import count_display_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_q,
  input  logic       i_ud,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_ud,
  output logic       o_valid
);

  conv_state_t r_state;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_bit_cnt;
  logic        r_ud;
  logic        r_valid;
  logic [11:0] w_adj;

  assign w_adj = bcd_adjust(r_bcd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_bit_cnt <= '0;
      r_ud      <= 1'b1;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Inputs are only sampled here; they are free to move during SHIFT/LOAD
          r_bin     <= i_q;
          r_ud      <= i_ud;
          r_bcd     <= '0;
          r_bit_cnt <= '0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_bcd     <= (w_adj << 1) | {11'd0, r_bin[7]};
          r_bin     <= r_bin << 1;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_state <= ST_LOAD;
            r_valid <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_hundreds = r_bcd[11:8];
  assign o_tens     = r_bcd[7:4];
  assign o_ones     = r_bcd[3:0];
  assign o_ud       = r_ud;
  assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/count_display.sv
`default_nettype none
//==============================================================================
// Module : count_display
// Brief  : Shows an 8-bit count and its direction on a multiplexed 4-digit display.
// Rev    : 1.0
//==============================================================================
module count_display
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic           clk,
  input  logic           reset_n,
  count_display_if.slave disp_bus
);

  localparam int c_presc_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(REFRESH_DIV - 1);

  logic [3:0]         w_hundreds;
  logic [3:0]         w_tens;
  logic [3:0]         w_ones;
  logic               w_dir;
  logic               w_valid;

  logic [c_presc_w-1:0] r_presc;
  logic [c_idx_w-1:0]   r_index;
  logic [3:0]           r_disp_h;
  logic [3:0]           r_disp_t;
  logic [3:0]           r_disp_o;
  logic                 r_disp_ud;
  logic [3:0]           r_an;
  logic [6:0]           r_seg;

  logic [3:0]           w_an_next;
  logic [6:0]           w_seg_next;

  bcd8_converter u_conv (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_q        (disp_bus.q),
    .i_ud       (disp_bus.ud),
    .o_hundreds (w_hundreds),
    .o_tens     (w_tens),
    .o_ones     (w_ones),
    .o_ud       (w_dir),
    .o_valid    (w_valid)
  );

  always_comb begin
    w_an_next  = ~(4'b0001 << r_index);
    w_seg_next = c_seg_blank;
    case (r_index)
      2'd0: w_seg_next = seg_decode(r_disp_o);
      2'd1: w_seg_next = (r_disp_h == 4'd0 && r_disp_t == 4'd0) ? c_seg_blank
                                                                 : seg_decode(r_disp_t);
      2'd2: w_seg_next = (r_disp_h == 4'd0) ? c_seg_blank : seg_decode(r_disp_h);
      2'd3: w_seg_next = r_disp_ud ? c_seg_u : c_seg_d;
      default: w_seg_next = c_seg_blank;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc   <= '0;
      r_index   <= '0;
      r_disp_h  <= '0;
      r_disp_t  <= '0;
      r_disp_o  <= '0;
      r_disp_ud <= 1'b1;
      r_an      <= 4'b1111;
      r_seg     <= c_seg_blank;
    end else begin
      if (r_presc == c_presc_last) begin
        r_presc <= '0;
        r_index <= r_index + c_idx_w'(1);
      end else begin
        r_presc <= r_presc + c_presc_w'(1);
      end
      // Only complete conversions reach the display, so no partial value is ever shown
      if (w_valid) begin
        r_disp_h  <= w_hundreds;
        r_disp_t  <= w_tens;
        r_disp_o  <= w_ones;
        r_disp_ud <= w_dir;
      end
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign disp_bus.an  = r_an;
  assign disp_bus.seg = r_seg;
  assign disp_bus.dp  = 1'b1;

endmodule
`default_nettype wire
